star_power_ctrl: RTL



---
 rtl/star_pkg.sv | 27 ++
 rtl/star_power_ctrl_if.sv | 37 +++
 rtl/star_power_ctrl_tick_prescaler.sv | 27 ++
 rtl/star_power_ctrl.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/star_pkg.sv
// Shared types and helpers for the star power-up controller and sibling object modules.
package star_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StPower,
    StWarn
  } star_state_e;

  // Default timing shared with the enemy and level-timer blocks
  localparam int unsigned DefTickDiv    = 250000;
  localparam int unsigned DefPowerTicks = 800;
  localparam int unsigned DefWarnTicks  = 200;
  localparam int unsigned DefBlinkTicks = 8;

  localparam int unsigned MaxStars = 32;

  function automatic logic [5:0] popcount(input logic [MaxStars-1:0] v);
    logic [5:0] c;
    c = '0;
    for (int i = 0; i < MaxStars; i++) begin
      c = c + 6'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/star_power_ctrl_if.sv
// Star touch inputs, hit input and power-up status outputs; combo only with STAR_COMBO_EN.
interface star_power_ctrl_if #(
  parameter int unsigned NUM_STARS = 4,
  parameter int unsigned CNT_W     = 8
);

  logic [NUM_STARS-1:0] touch_star;
  logic                 char_hit;
  logic [CNT_W-1:0]     star_count;
  logic                 collect_pulse;
  logic                 power_active;
  logic                 blink;
  logic                 hit_absorbed;
  logic                 char_dmg;
`ifdef STAR_COMBO_EN
  logic [2:0]           combo;

  modport master (
    output touch_star, char_hit,
    input  star_count, collect_pulse, power_active, blink, hit_absorbed, char_dmg, combo
  );
  modport slave (
    input  touch_star, char_hit,
    output star_count, collect_pulse, power_active, blink, hit_absorbed, char_dmg, combo
  );
`else
  modport master (
    output touch_star, char_hit,
    input  star_count, collect_pulse, power_active, blink, hit_absorbed, char_dmg
  );
  modport slave (
    input  touch_star, char_hit,
    output star_count, collect_pulse, power_active, blink, hit_absorbed, char_dmg
  );
`endif

endinterface

// File: rtl/star_power_ctrl_tick_prescaler.sv
// Free-running divider producing a one-cycle tick every TICK_DIV sys_clk cycles.
module tick_prescaler
  import star_pkg::*;
#(
  parameter int unsigned TICK_DIV = DefTickDiv
) (
  input  logic sys_clk,
  input  logic RST,
  output logic tick
);

  localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tick  = (cnt_q == CntW'(TICK_DIV - 1));
  assign cnt_d = tick ? '0 : cnt_q + CntW'(1);

  always_ff @(posedge sys_clk) begin
    if (RST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/star_power_ctrl.sv
// Star collection counter and invincibility timer with hit classification and warn blink.
// Define STAR_COMBO_EN for the combo counter and doubled score while powered.
module star_power_ctrl
  import star_pkg::*;
#(
  parameter int unsigned NUM_STARS   = 4,
  parameter int unsigned TICK_DIV    = DefTickDiv,
  parameter int unsigned POWER_TICKS = DefPowerTicks,
  parameter int unsigned WARN_TICKS  = DefWarnTicks,
  parameter int unsigned BLINK_TICKS = DefBlinkTicks,
  parameter int unsigned CNT_W       = 8
) (
  input logic               sys_clk,
  input logic               RST,
  star_power_ctrl_if.slave  bus
);

  localparam int unsigned TimerW = $clog2(POWER_TICKS + 1);
  localparam int unsigned BlinkW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

  logic                 tick;
  logic [NUM_STARS-1:0] prev_q, new_stars;
  logic [5:0]           n_new;
  logic [6:0]           inc;
  logic [CNT_W+2:0]     sum;
  logic                 powered, collect;

  star_state_e          state_q, state_d;
  logic [TimerW-1:0]    timer_q, timer_d;
  logic [BlinkW-1:0]    blink_cnt_q, blink_cnt_d;
  logic                 phase_q, phase_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 collect_q, absorbed_q, dmg_q;

  tick_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_prescaler (
    .sys_clk(sys_clk),
    .RST    (RST),
    .tick   (tick)
  );

  assign new_stars = bus.touch_star & ~prev_q;
  assign n_new     = popcount(MaxStars'(new_stars));
  assign collect   = |new_stars;
  assign powered   = (state_q != StIdle);

`ifdef STAR_COMBO_EN
  assign inc = powered ? {n_new, 1'b0} : {1'b0, n_new};
`else
  assign inc = {1'b0, n_new};
`endif

  // Wide sum so any overflow is visible in the top bits and clamps instead of wrapping
  assign sum     = {3'b000, count_q} + (CNT_W + 3)'(inc);
  assign count_d = (sum[CNT_W+2:CNT_W] != '0) ? '1 : sum[CNT_W-1:0];

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    unique case (state_q)
      StIdle: begin
        if (collect) begin
          state_d = StPower;
          timer_d = TimerW'(POWER_TICKS);
        end
      end
      StPower: begin
        if (collect) begin
          timer_d = TimerW'(POWER_TICKS);
        end else if (tick) begin
          timer_d = timer_q - TimerW'(1);
          if (timer_d == TimerW'(WARN_TICKS)) begin
            state_d     = StWarn;
            phase_d     = 1'b0;
            blink_cnt_d = '0;
          end
        end
      end
      StWarn: begin
        if (collect) begin
          state_d = StPower;
          timer_d = TimerW'(POWER_TICKS);
        end else if (tick) begin
          timer_d = timer_q - TimerW'(1);
          if (timer_d == '0) begin
            state_d = StIdle;
          end else if (blink_cnt_q == BlinkW'(BLINK_TICKS - 1)) begin
            blink_cnt_d = '0;
            phase_d     = ~phase_q;
          end else begin
            blink_cnt_d = blink_cnt_q + BlinkW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (RST) begin
      prev_q      <= '1;
      state_q     <= StIdle;
      timer_q     <= '0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
      count_q     <= '0;
      collect_q   <= 1'b0;
      absorbed_q  <= 1'b0;
      dmg_q       <= 1'b0;
    end else begin
      prev_q      <= bus.touch_star;
      state_q     <= state_d;
      timer_q     <= timer_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      count_q     <= count_d;
      collect_q   <= collect;
      absorbed_q  <= bus.char_hit & powered;
      dmg_q       <= bus.char_hit & ~powered;
    end
  end

`ifdef STAR_COMBO_EN
  logic [2:0] combo_q, combo_d;
  logic [6:0] combo_sum;

  assign combo_sum = 7'(combo_q) + 7'(n_new);

  always_comb begin
    combo_d = combo_q;
    if (state_d == StIdle) begin
      combo_d = '0;
    end else if (powered && collect) begin
      combo_d = (combo_sum > 7'd7) ? 3'd7 : combo_sum[2:0];
    end
  end

  always_ff @(posedge sys_clk) begin
    if (RST) begin
      combo_q <= '0;
    end else begin
      combo_q <= combo_d;
    end
  end

  assign bus.combo = combo_q;
`endif

  assign bus.star_count    = count_q;
  assign bus.collect_pulse = collect_q;
  assign bus.power_active  = powered;
  assign bus.blink         = (state_q == StPower) | ((state_q == StWarn) & phase_q);
  assign bus.hit_absorbed  = absorbed_q;
  assign bus.char_dmg      = dmg_q;

endmodule
